// File: rtl/regwrite_scheduler.sv
// Register-file write-back arbiter for the six-input write-data mux.
// Round-robin with optional strict-priority source and $0 discard.
module regwrite_scheduler #(
    parameter int NUM_SRC = 6,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      hold,
    input  logic                      prio_en,
    input  logic [2:0]                prio_src,
    output logic [2:0]                mux_selector,
    output logic                      reg_write,
    output logic [ADDR_W-1:0]         write_reg,
    output logic                      stall,
    output logic [15:0]               write_count
);

    logic [2:0]         r_rr_ptr;
    logic [15:0]        r_write_count;

    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_zero;
    logic [7:0]         w_elig_ext;
    logic               w_prio_ok;
    logic               w_rr_found;
    logic [2:0]         w_rr_idx;
    logic [3:0]         w_scan;
    logic               w_grant;
    logic [2:0]         w_win;
    logic [2:0]         w_ptr_next;
    logic [2:0]         w_n_elig;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [NUM_SRC-1:0] w_win_onehot;

    always_comb begin
        w_elig = '0;
        w_zero = '0;
        w_n_elig = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_elig[i] = src_valid[i] &&
                        (src_addr[i*ADDR_W +: ADDR_W] != '0);
            w_zero[i] = src_valid[i] &&
                        (src_addr[i*ADDR_W +: ADDR_W] == '0);
            w_n_elig = w_n_elig + {2'b00, w_elig[i]};
        end
    end

    // Padded so out-of-range prio_src (6, 7) reads as not eligible.
    assign w_elig_ext = {{(8-NUM_SRC){1'b0}}, w_elig};
    assign w_prio_ok  = prio_en && (prio_src < 3'(NUM_SRC)) &&
                        w_elig_ext[prio_src];

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan = {1'b0, r_rr_ptr} + 4'(k);
            if (w_scan >= 4'(NUM_SRC))
                w_scan = w_scan - 4'(NUM_SRC);
            if (!w_rr_found && w_elig[w_scan[2:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan[2:0];
            end
        end
    end

    assign w_grant = !hold && (w_prio_ok || w_rr_found);
    assign w_win   = w_prio_ok ? prio_src : w_rr_idx;
    assign w_ptr_next = (w_win == 3'(NUM_SRC-1)) ? 3'd0
                                                 : w_win + 3'd1;

    always_comb begin
        w_win_addr   = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant && (w_win == 3'(i))) begin
                w_win_addr      = src_addr[i*ADDR_W +: ADDR_W];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        src_ready    = '0;
        reg_write    = 1'b0;
        mux_selector = '0;
        write_reg    = '0;
        stall        = 1'b0;
        if (reset) begin
            src_ready = w_win_onehot | w_zero;
            reg_write = w_grant;
            if (w_grant) begin
                mux_selector = w_win;
                write_reg    = w_win_addr;
            end
            stall = w_n_elig > {2'b00, w_grant};
        end
    end

    assign write_count = r_write_count;

    // Priority grants leave the pointer so round-robin order is preserved.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_write_count <= '0;
        end else begin
            if (w_grant && !w_prio_ok)
                r_rr_ptr <= w_ptr_next;
            if (w_grant && (r_write_count != 16'hFFFF))
                r_write_count <= r_write_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_regwrite_scheduler.sv
// Scoreboard bench for regwrite_scheduler: directed vectors queued
// by the stimulus process, compared by an independent monitor.
module tb_regwrite_scheduler;

    logic        clk;
    logic        reset;
    logic [5:0]  src_valid;
    logic [29:0] src_addr;
    logic [5:0]  src_ready;
    logic        hold;
    logic        prio_en;
    logic [2:0]  prio_src;
    logic [2:0]  mux_selector;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic        stall;
    logic [15:0] write_count;

    regwrite_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .src_ready    (src_ready),
        .hold         (hold),
        .prio_en      (prio_en),
        .prio_src     (prio_src),
        .mux_selector (mux_selector),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .stall        (stall),
        .write_count  (write_count)
    );

    typedef struct {
        string       name;
        logic [5:0]  rdy;
        logic        rw;
        logic [2:0]  mux;
        logic [4:0]  wr;
        logic        st;
        logic        cnt_chk;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_cnt = 0;
    logic        cnt_known = 0;
    logic        done = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step(
        input logic r, input logic [5:0] v, input logic [29:0] a,
        input logic h, input logic pe, input logic [2:0] ps,
        input string nm, input logic [5:0] erdy, input logic erw,
        input logic [2:0] emux, input logic [4:0] ewr, input logic est);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; src_valid = v; src_addr = a;
        hold = h; prio_en = pe; prio_src = ps;
        e.name = nm; e.rdy = erdy; e.rw = erw; e.mux = emux;
        e.wr = ewr; e.st = est; e.cnt_chk = cnt_known; e.cnt = exp_cnt;
        q.push_back(e);
        if (!r) begin
            exp_cnt = 0;
            cnt_known = 1;
        end else if (erw && exp_cnt != 16'hFFFF) begin
            exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ok;
            e = q.pop_front();
            ok = (src_ready === e.rdy) && (reg_write === e.rw) &&
                 (mux_selector === e.mux) && (write_reg === e.wr) &&
                 (stall === e.st);
            if (e.cnt_chk) ok = ok && (write_count === e.cnt);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got rdy=%b rw=%b mux=%0d wr=%0d st=%b cnt=%h; expected rdy=%b rw=%b mux=%0d wr=%0d st=%b cnt=%h",
                    e.name, src_ready, reg_write, mux_selector,
                    write_reg, stall, write_count, e.rdy, e.rw, e.mux,
                    e.wr, e.st, e.cnt);
            end
        end
    end

    localparam logic [29:0] A16 = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};

    initial begin
        reset = 0; src_valid = 0; src_addr = 0;
        hold = 0; prio_en = 0; prio_src = 0;

        step(0, 6'h3F, A16, 0, 0, 0, "rst0", 6'h00, 0, 0, 0, 0);
        step(0, 6'h3F, A16, 0, 0, 0, "rst1", 6'h00, 0, 0, 0, 0);

        // Each source drops its request after being acked.
        for (int k = 0; k < 6; k++) begin
            logic [5:0] v;
            v = 6'h3F & ~((6'd1 << k) - 6'd1);
            step(1, v, A16, 0, 0, 0, $sformatf("rr%0d", k),
                 6'd1 << k, 1, 3'(k), 5'(k + 1), (6 - k) > 1);
        end
        step(1, 6'h01, A16, 0, 0, 0, "rr_wrap", 6'h01, 1, 0, 1, 0);
        step(1, 6'h00, A16, 0, 0, 0, "cnt7", 6'h00, 0, 0, 0, 0);

        step(0, 6'h00, 30'd0, 0, 0, 0, "rst2", 6'h00, 0, 0, 0, 0);
        step(1, 6'b000101, {5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0},
             0, 0, 0, "zero_discard", 6'b000101, 1, 2, 9, 0);

        step(0, 6'h00, 30'd0, 0, 0, 0, "rst3", 6'h00, 0, 0, 0, 0);
        step(1, 6'b010001, {5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd3},
             0, 1, 4, "prio4", 6'b010000, 1, 4, 7, 1);
        step(1, 6'b010001, {5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd3},
             0, 0, 0, "ptr_kept", 6'b000001, 1, 0, 3, 1);
        step(1, 6'b010001, {5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd3},
             0, 1, 7, "prio7_rr", 6'b010000, 1, 4, 7, 1);
        step(1, 6'b000101, {5'd0, 5'd0, 5'd0, 5'd8, 5'd0, 5'd3},
             0, 1, 6, "prio6_rr", 6'b000001, 1, 0, 3, 1);
        step(1, 6'b010100, {5'd0, 5'd7, 5'd0, 5'd8, 5'd0, 5'd0},
             0, 1, 3, "prio_inelig", 6'b000100, 1, 2, 8, 1);

        step(0, 6'h00, 30'd0, 0, 0, 0, "rst4", 6'h00, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            step(1, 6'b001010, {5'd0, 5'd0, 5'd11, 5'd0, 5'd10, 5'd0},
                 1, 0, 0, $sformatf("hold%0d", k), 6'h00, 0, 0, 0, 1);
        step(1, 6'b101010, {5'd0, 5'd0, 5'd11, 5'd0, 5'd10, 5'd0},
             1, 0, 0, "hold_zero", 6'b100000, 0, 0, 0, 1);
        step(1, 6'b001010, {5'd0, 5'd0, 5'd11, 5'd0, 5'd10, 5'd0},
             0, 0, 0, "release1", 6'b000010, 1, 1, 10, 1);
        step(1, 6'b001000, {5'd0, 5'd0, 5'd11, 5'd0, 5'd10, 5'd0},
             0, 0, 0, "release3", 6'b001000, 1, 3, 11, 0);
        step(0, 6'b000010, {5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 5'd0},
             0, 0, 0, "mid_reset", 6'h00, 0, 0, 0, 0);
        step(1, 6'b000010, {5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 5'd0},
             0, 0, 0, "after_reset", 6'b000010, 1, 1, 10, 0);

        step(0, 6'h00, 30'd0, 0, 0, 0, "rst5", 6'h00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1; src_valid = 6'h01; src_addr = 30'd1;
        hold = 0; prio_en = 0; prio_src = 0;
        repeat (65534) @(posedge clk);
        exp_cnt = 16'hFFFF;
        step(1, 6'h01, 30'd1, 0, 0, 0, "sat_reach", 6'h01, 1, 0, 1, 0);
        step(1, 6'h01, 30'd1, 0, 0, 0, "sat_hold", 6'h01, 1, 0, 1, 0);
        step(1, 6'h00, 30'd0, 0, 0, 0, "sat_final", 6'h00, 0, 0, 0, 0);
        done = 1;
    end

    initial begin
        int cyc;
        cyc = 0;
        wait (done == 1);
        while (q.size() > 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regwrite_scheduler.md
Name: regwrite_scheduler

Overview:
- Arbitrates register-file write-back among the six write-data sources feeding the 6:1 write-data mux (ALU, memory load, HI, LO, shifter, PC+4 / LUI; source index = mux input index 0..5).
- Each cycle, grants at most one real register write and drives the mux selector, reg_write and write_reg to match.
- Round-robin fairness is kept in a registered pointer; optional strict-priority override for one source.
- Sits between the multicycle control unit / functional units and the register file.

Parameters:
- NUM_SRC, 6, number of requesters; fixed by the mux width, not to be changed.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- src_valid  in  6  per-source write request; bit i = mux input i.
- src_addr  in  30  destination register per source; bits [5i+4:5i] belong to source i.
- src_ready  out  6  write accepted this cycle; source may drop or change its request next cycle.
- hold  in  1  freeze: no grants while high.
- prio_en  in  1  strict-priority override enable.
- prio_src  in  3  source index given strict priority when prio_en=1.
- mux_selector  out  3  drives the write-data mux selector.
- reg_write  out  1  register-file write enable.
- write_reg  out  5  register-file write address.
- stall  out  1  at least one nonzero-address request is valid and not accepted this cycle.
- write_count  out  16  number of real writes performed, saturating.

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset).
- Reset state:
  - While reset=0, all outputs are forced combinationally to 0: src_ready, reg_write, write_reg, mux_selector, stall.
  - At the clock edge with reset=0: rr_ptr <= 0 and write_count <= 0.
- Outputs are combinational from inputs plus registered state. Zero-latency grant: the register file samples data at the same rising edge at which the handshake completes.
- Sources must hold src_valid, src_addr and their data stable until they see src_ready.
- Eligibility: source i is eligible when src_valid[i]=1 and its address is nonzero.
- Winner selection, highest rule wins:
  1. hold=1: no winner.
  2. prio_en=1, prio_src<6 and prio_src eligible: winner = prio_src.
  3. Otherwise, the first eligible index scanning rr_ptr, rr_ptr+1, … wrapping 5→0.
- prio_src values 6 and 7 are ignored (treated as prio_en=0).
- When a winner w exists: mux_selector=w, write_reg=src_addr[w], reg_write=1, src_ready[w]=1.
- When there is no winner: reg_write=0, mux_selector=0, write_reg=0.
- $0 discard: every source with src_valid=1 and address 0 gets src_ready=1 in the same cycle, with no write. This is independent of the winner and applies even when hold=1. Such requests never set stall.
- stall = (number of eligible sources) > (1 if a winner exists else 0). hold=1 with any eligible source ⇒ stall=1.
- rr_ptr update at the clock edge:
  - On a grant won via rule 3: rr_ptr <= w+1, with 5 wrapping to 0.
  - On a grant via rule 2, or on no grant: rr_ptr unchanged.
- write_count increments on each cycle with reg_write=1 and saturates at 16'hFFFF.
- Two sources targeting the same register in one cycle: only one writes per cycle. The other writes in a later cycle, so the last write wins in grant order. No merging.
- src_valid dropping before src_ready is legal (request withdrawn); no state is retained for it.
- Reset asserted mid-stream: the pending request is not granted that cycle and the pointer returns to 0. Sources keep their requests and are served after release.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all src_valid=6'h3F → src_ready=0, reg_write=0, stall=0. After release, the first grant goes to source 0 (mux_selector=0).
- Round-robin: all six valid, addresses 1..6, never dropped until acked → grants 0,1,2,3,4,5 on consecutive cycles, write_reg 1..6. rr_ptr wraps; a 7th request from source 0 is granted on cycle 7. write_count=7.
- $0 discard: src0 addr 0, src2 addr 9 both valid, rr_ptr=0 → src_ready=6'b000101, reg_write=1, mux_selector=2, write_reg=9, stall=0.
- Priority override: rr_ptr=0, sources 0 and 4 valid (addr 3, 7), prio_en=1, prio_src=4 → grant 4, write_reg=7, rr_ptr stays 0. Next cycle grant 0. Then prio_src=7 with prio_en=1 → pure round-robin.
- Hold: hold=1 for 3 cycles with sources 1 and 3 valid → reg_write=0, stall=1, src_ready=0. Release → grant 1, then 3.
- Saturation: preload via 65 535 writes → write_count=16'hFFFF; one more write → stays 16'hFFFF while reg_write=1.
